// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled period counter, double-buffered duty bank committed at wrap.
// Define PWM_MULTI_STAGGER_EN to phase-stagger channels evenly across the period.
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRE_W    = 8,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PRE_W-1:0]    prescale,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_value,
  output logic [CHANNELS-1:0] out,
  output logic                period_end,
  output logic                pending
);

  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

  logic [PRE_W-1:0] pre_cnt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] shadow [CHANNELS];
  logic [WIDTH-1:0] active [CHANNELS];
  logic [WIDTH-1:0] cnt_ch [CHANNELS];
  logic             tick;
  logic             wrap;
  logic             wr_ok;

  assign tick  = enable && (pre_cnt == prescale);
  assign wrap  = tick && (&cnt);
  assign wr_ok = wr_en && ({1'b0, wr_ch} < CH_LIMIT);

  // Per-channel compare count; staggered builds offset each channel by an equal phase slice
`ifdef PWM_MULTI_STAGGER_EN
  localparam int STEP = (1 << WIDTH) / CHANNELS;
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_ch[i] = cnt + WIDTH'(i * STEP);
    end
  end
`else
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_ch[i] = cnt;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt    <= '0;
      cnt        <= '0;
      out        <= '0;
      period_end <= 1'b0;
      pending    <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (enable) begin
        if (pre_cnt == prescale) pre_cnt <= '0;
        else                     pre_cnt <= pre_cnt + 1'b1;
      end
      if (tick) cnt <= cnt + 1'b1;

      // Commit reads shadow before any same-cycle write, so that write waits for the next wrap
      if (wrap) begin
        for (int i = 0; i < CHANNELS; i++) begin
          active[i] <= shadow[i];
        end
        pending <= 1'b0;
      end
      if (wr_ok) begin
        shadow[wr_ch] <= wr_value;
        pending       <= 1'b1;
      end

      period_end <= wrap;
      for (int i = 0; i < CHANNELS; i++) begin
        out[i] <= (active[i] > cnt_ch[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: windowed high-time/pulse measurements checked against a scoreboard queue.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] prescale;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [7:0] wr_value;
  logic [3:0] out;
  logic       period_end;
  logic       pending;

  logic       wr_en3;
  logic [1:0] wr_ch3;
  logic [7:0] wr_value3;
  logic [2:0] out3;
  logic       period_end3;
  logic       pending3;

  int checks   = 0;
  int failures = 0;

  // meas[0..3] high clocks, 4 period_end pulses, 5 ch0 rises, 6..9 first rise index, 10 cycles off ref_out
  int         meas [11];
  logic [3:0] ref_out;

  typedef struct {
    int    kind;
    int    value;
    string tag;
  } exp_t;
  exp_t sb_q[$];

  pwm_multi #(.WIDTH(8), .CHANNELS(4), .PRE_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .prescale(prescale),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_value(wr_value),
    .out(out), .period_end(period_end), .pending(pending)
  );

  pwm_multi #(.WIDTH(8), .CHANNELS(3), .PRE_W(8)) dut3 (
    .clk(clk), .reset(reset), .enable(1'b0), .prescale(prescale),
    .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_value(wr_value3),
    .out(out3), .period_end(period_end3), .pending(pending3)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] ch, input logic [7:0] val);
    wr_en    = 1'b1;
    wr_ch    = ch;
    wr_value = val;
    step();
    wr_en    = 1'b0;
  endtask

  task automatic push_exp(input int kind, input int value, input string tag);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    e.tag   = tag;
    sb_q.push_back(e);
  endtask

  task automatic drain_scoreboard();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_output(e.tag, meas[e.kind], e.value);
    end
  endtask

  task automatic measure(input int n);
    logic [3:0] prev;
    prev = out;
    for (int k = 0; k < 11; k++) meas[k] = 0;
    for (int k = 6; k < 10; k++) meas[k] = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (out[i] === 1'b1) meas[i]++;
        if (out[i] === 1'b1 && prev[i] !== 1'b1 && meas[6+i] < 0) meas[6+i] = k;
      end
      if (out[0] === 1'b1 && prev[0] !== 1'b1) meas[5]++;
      if (period_end === 1'b1) meas[4]++;
      if (out !== ref_out) meas[10]++;
      prev = out;
    end
  endtask

  task automatic wait_period_end(input int budget, input string tag);
    int n;
    n = 0;
    while (period_end !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check_output(tag, period_end, 1);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    prescale  = 8'd0;
    wr_en     = 1'b0;
    wr_ch     = 2'd0;
    wr_value  = 8'd0;
    wr_en3    = 1'b0;
    wr_ch3    = 2'd0;
    wr_value3 = 8'd0;
    ref_out   = 4'b0000;
    repeat (3) step();
    check_output("reset_out", out, 0);
    check_output("reset_pending", pending, 0);
    check_output("reset_period_end", period_end, 0);
    reset = 1'b0;

    // Out-of-range channel on a 3-channel build must be ignored
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_value3 = 8'hAA;
    step();
    check_output("ch3_invalid_pending", pending3, 0);
    wr_ch3 = 2'd2;
    step();
    check_output("ch3_valid_pending", pending3, 1);
    wr_ch3 = 2'd3;
    step();
    wr_en3 = 1'b0;
    check_output("ch3_invalid_keeps_pending", pending3, 1);

    // Basic duty, prescale 0
    enable = 1'b1;
    apply_stimulus(2'd0, 8'h40);
    check_output("pending_after_write", pending, 1);
    apply_stimulus(2'd1, 8'h00);
    apply_stimulus(2'd2, 8'hFF);
    apply_stimulus(2'd3, 8'h80);
    check_output("out_before_commit", out, 0);
    wait_period_end(300, "basic_commit_seen");
    check_output("basic_pending_cleared", pending, 0);
    check_output("basic_out_latency", out, 0);
    push_exp(0, 64,  "basic_ch0_high");
    push_exp(1, 0,   "basic_ch1_high");
    push_exp(2, 255, "basic_ch2_high");
    push_exp(3, 128, "basic_ch3_high");
    push_exp(4, 1,   "basic_period_end_pulses");
    measure(256);
    drain_scoreboard();
    check_output("basic_period_end_at_256", period_end, 1);

    // Prescaler 3: 1024-clock period
    prescale = 8'd3;
    apply_stimulus(2'd0, 8'h10);
    wait_period_end(1100, "presc_commit_seen");
    push_exp(0, 64,   "presc_ch0_high");
    push_exp(5, 1,    "presc_ch0_single_run");
    push_exp(2, 1020, "presc_ch2_high");
    push_exp(3, 512,  "presc_ch3_high");
    push_exp(4, 1,    "presc_period_end_pulses");
    measure(1024);
    drain_scoreboard();
    check_output("presc_period_end_at_1024", period_end, 1);

    // Double buffer: mid-period write holds old duty; write on the wrap cycle slips one period
    prescale = 8'd0;
    push_exp(0, 16, "dbuf_old_duty_head");
    measure(8'h50);
    drain_scoreboard();
    apply_stimulus(2'd0, 8'h20);
    check_output("dbuf_pending_mid", pending, 1);
    push_exp(0, 0, "dbuf_old_duty_tail");
    push_exp(4, 0, "dbuf_no_early_commit");
    measure(174);
    drain_scoreboard();
    check_output("dbuf_pending_before_wrap", pending, 1);
    apply_stimulus(2'd0, 8'h30);
    check_output("dbuf_wrap_period_end", period_end, 1);
    check_output("dbuf_wrap_write_pending", pending, 1);
    push_exp(0, 32, "dbuf_new_duty");
    push_exp(4, 1,  "dbuf_pulses_1");
    measure(256);
    drain_scoreboard();
    check_output("dbuf_pending_cleared", pending, 0);
    push_exp(0, 48, "dbuf_wrap_write_duty");
    measure(256);
    drain_scoreboard();

    // Enable low at count 0x30 freezes the outputs
    measure(8'h30);
    enable = 1'b0;
    step();
`ifdef PWM_MULTI_STAGGER_EN
    ref_out = 4'b0100;
`else
    ref_out = 4'b1100;
`endif
    check_output("freeze_out", out, ref_out);
    apply_stimulus(2'd1, 8'h77);
    check_output("freeze_write_pending", pending, 1);
    push_exp(10, 0, "freeze_out_static");
    push_exp(4, 0,  "freeze_no_period_end");
    measure(100);
    drain_scoreboard();
    ref_out = 4'b0000;
    enable = 1'b1;

    // Equal duties: rising-edge phase per channel
    apply_stimulus(2'd0, 8'h40);
    apply_stimulus(2'd1, 8'h40);
    apply_stimulus(2'd2, 8'h40);
    apply_stimulus(2'd3, 8'h40);
    wait_period_end(300, "phase_commit_seen");
`ifdef PWM_MULTI_STAGGER_EN
    push_exp(6, 1,   "phase_ch0_rise");
    push_exp(7, 193, "phase_ch1_rise");
    push_exp(8, 129, "phase_ch2_rise");
    push_exp(9, 65,  "phase_ch3_rise");
`else
    push_exp(6, 1, "phase_ch0_rise");
    push_exp(7, 1, "phase_ch1_rise");
    push_exp(8, 1, "phase_ch2_rise");
    push_exp(9, 1, "phase_ch3_rise");
`endif
    push_exp(1, 64, "phase_ch1_high");
    measure(256);
    drain_scoreboard();

    // Asynchronous reset mid-period discards pending writes
    apply_stimulus(2'd0, 8'h80);
    apply_stimulus(2'd1, 8'h80);
    repeat (10) step();
    check_output("prereset_ch0_high", out[0], 1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_out", out, 0);
    check_output("async_reset_pending", pending, 0);
    check_output("async_reset_period_end", period_end, 0);
    step();
    reset = 1'b0;
    push_exp(10, 0, "postreset_out_low");
    push_exp(4, 1,  "postreset_period_end");
    measure(300);
    drain_scoreboard();
    check_output("postreset_pending", pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
